alu_ctrl_seq: RTL

// Registered, parametrised successor to the combinational ALU control decode. Decodes
// op/fun into the 4-bit ALU control code. Sequences multi-cycle multiply/divide with a

---
 rtl/alu_ctrl_seq.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: registered ALU control decode with valid/ready and multi-cycle mul/div sequencing.
// Define MULDIV_EN to build the mult/div decode, the MD_BUSY FSM and the latency counter.
module alu_ctrl_seq #(
   parameter int unsigned MUL_LAT = 4,
   parameter int unsigned DIV_LAT = 16,
   parameter int unsigned CNT_W   = 5
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [2:0] op,
   input  logic [5:0] fun,
   input  logic       flush,
   output logic [3:0] alu_ctrl,
   output logic       out_valid,
   output logic       hilo_we,
   output logic       md_busy,
   output logic       illegal
);

   logic [3:0] dec_ctrl;
   logic       dec_illegal;
   logic       dec_md;
   logic       dec_div;
   logic [3:0] ctrl_q, ctrl_d;
   logic       valid_q, valid_d;
   logic       illegal_q, illegal_d;

   always_comb begin
      dec_ctrl    = 4'b0010;
      dec_illegal = 1'b0;
      dec_md      = 1'b0;
      dec_div     = 1'b0;
      case (op)
         3'b000: dec_ctrl = 4'b0010;
         3'b001: dec_ctrl = 4'b0011;
         3'b011: dec_ctrl = 4'b1010;
         3'b100: dec_ctrl = 4'b0000;
         3'b101: dec_ctrl = 4'b0001;
         3'b110: dec_ctrl = 4'b0100;
         3'b111: dec_ctrl = 4'b0101;
         3'b010: begin
            case (fun)
               6'b100000, 6'b100001: dec_ctrl = 4'b1010;
               6'b100010:            dec_ctrl = 4'b1011;
               6'b100011:            dec_ctrl = 4'b0011;
               6'b100100, 6'b010100: dec_ctrl = 4'b0000;
               6'b100101:            dec_ctrl = 4'b0001;
               6'b100111:            dec_ctrl = 4'b0111;
               6'b101010:            dec_ctrl = 4'b0100;
               6'b101011:            dec_ctrl = 4'b0101;
`ifdef MULDIV_EN
               6'b011000: begin dec_ctrl = 4'b1110; dec_md = 1'b1; end
               6'b011001: begin dec_ctrl = 4'b1100; dec_md = 1'b1; end
               6'b011010: begin dec_ctrl = 4'b1111; dec_md = 1'b1; dec_div = 1'b1; end
               6'b011011: begin dec_ctrl = 4'b1101; dec_md = 1'b1; dec_div = 1'b1; end
`endif
               default:              dec_illegal = 1'b1;
            endcase
         end
         default: dec_ctrl = 4'b0010;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ctrl_q    <= 4'b0010;
         valid_q   <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         ctrl_q    <= ctrl_d;
         valid_q   <= valid_d;
         illegal_q <= illegal_d;
      end
   end

   assign alu_ctrl  = ctrl_q;
   assign out_valid = valid_q;
   assign illegal   = illegal_q;

`ifdef MULDIV_EN
   typedef enum logic {StIdle, StMdBusy} state_e;

   localparam logic [CNT_W-1:0] MulLat = CNT_W'(MUL_LAT);
   localparam logic [CNT_W-1:0] DivLat = CNT_W'(DIV_LAT);
   localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] lat;
   logic             hilo_q, hilo_d;

   assign lat = dec_div ? DivLat : MulLat;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         hilo_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hilo_q  <= hilo_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      ctrl_d    = ctrl_q;
      valid_d   = 1'b0;
      hilo_d    = 1'b0;
      illegal_d = 1'b0;
      // A squash wins over both a new request and a completing mul/div.
      if (flush) begin
         state_d = StIdle;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (in_valid) begin
                  ctrl_d = dec_ctrl;
                  if (!dec_md) begin
                     valid_d   = 1'b1;
                     illegal_d = dec_illegal;
                  end else if (lat == CntOne) begin
                     valid_d = 1'b1;
                     hilo_d  = 1'b1;
                  end else begin
                     state_d = StMdBusy;
                     cnt_d   = lat - CntOne;
                  end
               end
            end
            StMdBusy: begin
               if (cnt_q == CntOne) begin
                  state_d = StIdle;
                  cnt_d   = '0;
                  valid_d = 1'b1;
                  hilo_d  = 1'b1;
               end else begin
                  cnt_d = cnt_q - CntOne;
               end
            end
         endcase
      end
   end

   assign in_ready = (state_q == StIdle);
   assign md_busy  = (state_q == StMdBusy);
   assign hilo_we  = hilo_q;
`else
   logic unused_cfg;
   assign unused_cfg = ^{MUL_LAT, DIV_LAT, CNT_W, dec_md, dec_div};

   always_comb begin
      ctrl_d    = ctrl_q;
      valid_d   = 1'b0;
      illegal_d = 1'b0;
      if (in_valid && !flush) begin
         ctrl_d    = dec_ctrl;
         valid_d   = 1'b1;
         illegal_d = dec_illegal;
      end
   end

   assign in_ready = 1'b1;
   assign md_busy  = 1'b0;
   assign hilo_we  = 1'b0;
`endif

endmodule
